// File: rtl/ctrl_pkg.sv
// Shared constants, field positions and FSM encoding for the serial control link.
package ctrl_pkg;

  localparam int unsigned CTRL_W          = 16;
  localparam int unsigned CTRL_RESET_BIT  = 0;
  localparam int unsigned CTRL_ENABLE_BIT = 1;
  localparam int unsigned CTRL_SPEED_LSB  = 2;
  localparam int unsigned CTRL_SPEED_MSB  = 3;
  localparam int unsigned CTRL_TEST_BIT   = 4;

  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned HALF_W    = 8;
  localparam int unsigned GAP_W     = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_GAP  = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic       test;
    logic [1:0] speed;
    logic       enable;
    logic       reset;
  } ctrl_fields_t;

  // Extract the defined control fields from a received word.
  function automatic ctrl_fields_t ctrl_decode(input logic [CTRL_W-1:0] w);
    ctrl_fields_t f;
    f.reset  = w[CTRL_RESET_BIT];
    f.enable = w[CTRL_ENABLE_BIT];
    f.speed  = w[CTRL_SPEED_MSB:CTRL_SPEED_LSB];
    f.test   = w[CTRL_TEST_BIT];
    return f;
  endfunction

endpackage

// File: rtl/ctrl_tx.sv
// Serial control-word transmitter: 16 bits MSB first, data sampled on ctrl_clk_o rise,
// followed by an inter-frame gap that ends with a done_o pulse.
module ctrl_tx
  import ctrl_pkg::*;
#(
  parameter int unsigned DIV = 4,
  parameter int unsigned GAP = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [CTRL_W-1:0] word_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ctrl_clk_o,
  output logic              ctrl_data_o
);

  localparam logic [HALF_W-1:0]    HALF_LAST = HALF_W'(DIV - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_FIRST = BIT_CNT_W'(CTRL_W - 1);

  ctrl_state_e          state, state_n;
  logic [CTRL_W-1:0]    shreg, shreg_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [HALF_W-1:0]    half_cnt, half_cnt_n;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_n;
  logic                 clk_n, data_n, done_n;

  assign busy_o  = (state != ST_IDLE);
  assign ready_o = (state == ST_IDLE) && !reset_i;

  // State, datapath and registered serial outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      half_cnt    <= '0;
      gap_cnt     <= '0;
      ctrl_clk_o  <= 1'b0;
      ctrl_data_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      half_cnt    <= half_cnt_n;
      gap_cnt     <= gap_cnt_n;
      ctrl_clk_o  <= clk_n;
      ctrl_data_o <= data_n;
      done_o      <= done_n;
    end
  end

  // Next-state logic; outputs are precomputed from the next state so they line up with it.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    half_cnt_n = half_cnt;
    gap_cnt_n  = gap_cnt;
    clk_n      = 1'b0;
    data_n     = 1'b0;
    done_n     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (valid_i && ready_o) begin
          shreg_n    = word_i;
          bit_cnt_n  = BIT_FIRST;
          half_cnt_n = '0;
          state_n    = ST_LOW;
        end
      end
      ST_LOW: begin
        if (half_cnt == HALF_LAST) begin
          half_cnt_n = '0;
          state_n    = ST_HIGH;
        end else begin
          half_cnt_n = half_cnt + HALF_W'(1);
        end
      end
      ST_HIGH: begin
        if (half_cnt == HALF_LAST) begin
          half_cnt_n = '0;
          if (bit_cnt != '0) begin
            shreg_n   = {shreg[CTRL_W-2:0], 1'b0};
            bit_cnt_n = bit_cnt - BIT_CNT_W'(1);
            state_n   = ST_LOW;
          end else begin
            gap_cnt_n = '0;
            state_n   = ST_GAP;
          end
        end else begin
          half_cnt_n = half_cnt + HALF_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_n = '0;
          state_n   = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    clk_n  = (state_n == ST_HIGH);
    data_n = ((state_n == ST_LOW) || (state_n == ST_HIGH)) ? shreg_n[CTRL_W-1] : 1'b0;
    done_n = (state_n == ST_GAP) && (gap_cnt_n == GAP_LAST);
  end

endmodule

// File: tb/tb_ctrl_tx.sv
// Scoreboard bench for ctrl_tx: random and directed frames, serial decode monitor, reset abort, DIV=1.
module tb_ctrl_tx;
  import ctrl_pkg::*;

  localparam int unsigned DIV   = 4;
  localparam int unsigned GAP   = 16;
  localparam int unsigned FRAME = 32 * DIV + GAP;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] word_i;
  logic        valid_i;
  logic        ready_o, busy_o, done_o, ctrl_clk_o, ctrl_data_o;

  logic [15:0] word1;
  logic        valid1;
  logic        ready1, busy1, done1, cclk1, cdata1;

  always #5 clk_i = ~clk_i;

  ctrl_tx #(.DIV(DIV), .GAP(GAP)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .word_i(word_i), .valid_i(valid_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .ctrl_clk_o(ctrl_clk_o), .ctrl_data_o(ctrl_data_o)
  );

  ctrl_tx #(.DIV(1), .GAP(2)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .word_i(word1), .valid_i(valid1),
    .ready_o(ready1), .busy_o(busy1), .done_o(done1),
    .ctrl_clk_o(cclk1), .ctrl_data_o(cdata1)
  );

  typedef struct {
    logic [15:0] word;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_acc = 0;

  logic [15:0] rx_sh = '0;
  logic [15:0] last_rx = '0;
  int          rx_edges = 0;
  int          hi_run = 0;
  int          rdy_run = 0;
  int          rx_count = 0;
  logic        prev_clk = 1'b0;
  logic        hi_data = 1'b0;
  logic        aborted = 1'b1;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: decodes the serial link like the receiver and scores each completed frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        q.delete();
        rx_edges = 0;
        hi_run   = 0;
        rdy_run  = 0;
        prev_clk = 1'b0;
        aborted  = 1'b1;
      end else begin
        if (ctrl_clk_o && !prev_clk) begin
          rx_sh    = {rx_sh[14:0], ctrl_data_o};
          rx_edges = rx_edges + 1;
          hi_data  = ctrl_data_o;
          hi_run   = 1;
        end else if (ctrl_clk_o) begin
          hi_run = hi_run + 1;
          check("data_stable_high", 32'(ctrl_data_o), 32'(hi_data));
        end
        if (!ctrl_clk_o && prev_clk) check("high_len", hi_run, DIV);

        if (!ready_o) begin
          rdy_run = rdy_run + 1;
        end else begin
          if (rdy_run > 0 && !aborted) check("ready_gap", rdy_run, FRAME);
          rdy_run = 0;
          aborted = 1'b0;
        end

        if (done_o) begin
          check("done_expected", 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("rx_word", 32'(rx_sh), 32'(e.word));
            check("rx_edges", rx_edges, 16);
            check("frame_len", cyc - e.acc + 1, FRAME);
            rx_count = rx_count + 1;
          end
          last_rx  = rx_sh;
          rx_edges = 0;
        end
        prev_clk = ctrl_clk_o;
      end
    end
  end

  // Present a word with valid held until accepted; returns at the negedge after the accept.
  task automatic send(input logic [15:0] w);
    int t;
    t = 0;
    word_i  = w;
    valid_i = 1'b1;
    while (!ready_o && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    check("accept_in_time", 32'(ready_o), 1);
    if (ready_o) begin
      exp_t e;
      e.word   = w;
      e.acc    = cyc + 1;
      last_acc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || !ready_o) && t < 5000) begin
      @(negedge clk_i);
      t++;
    end
    check("drain_in_time", 32'(t < 5000), 1);
  endtask

  initial begin
    ctrl_fields_t f;
    int a1, a2, t, err_clk, err_data, err_done, edges1;
    logic pc;

    reset_i = 1'b1;
    word_i  = '0;
    valid_i = 1'b0;
    word1   = '0;
    valid1  = 1'b0;

    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 32'(ready_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ctrl_clk", 32'(ctrl_clk_o), 0);
    check("rst_ctrl_data", 32'(ctrl_data_o), 0);
    check("rst_done", 32'(done_o), 0);
    reset_i = 1'b0;
    #1;
    check("ready_after_release", 32'(ready_o), 1);
    @(negedge clk_i);

    // Single frame 001B
    send(16'h001B);
    check("busy_first_low", 32'(busy_o), 1);
    check("clk_first_low", 32'(ctrl_clk_o), 0);
    wait_idle();

    // Loopback field decode of 0013
    send(16'h0013);
    wait_idle();
    f = ctrl_decode(last_rx);
    check("f_reset", 32'(f.reset), 1);
    check("f_enable", 32'(f.enable), 1);
    check("f_speed", 32'(f.speed), 0);
    check("f_test", 32'(f.test), 1);

    // Back-to-back with valid held high; word changes during the first frame
    send(16'hA5A5);
    a1 = last_acc;
    send(16'h5A5A);
    a2 = last_acc;
    check("b2b_spacing", a2 - a1, FRAME + 1);
    wait_idle();

    // Randomized traffic; word_i churns while busy
    for (int i = 0; i < 2500; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      word_i  = 16'($urandom);
      if (valid_i && ready_o) begin
        exp_t e;
        e.word = word_i;
        e.acc  = cyc + 1;
        q.push_back(e);
      end
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    wait_idle();
    check("frames_seen", 32'(rx_count > 15), 1);

    // Reset after the 7th rising edge of ctrl_clk_o aborts the frame
    send(16'hC3C3);
    t = 0;
    while (rx_edges < 7 && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    check("seventh_edge_in_time", 32'(rx_edges), 7);
    check("clk_high_before_abort", 32'(ctrl_clk_o), 1);
    #2;
    reset_i = 1'b1;
    #1;
    check("abort_ctrl_clk", 32'(ctrl_clk_o), 0);
    check("abort_ctrl_data", 32'(ctrl_data_o), 0);
    check("abort_ready", 32'(ready_o), 0);
    check("abort_busy", 32'(busy_o), 0);
    check("abort_done", 32'(done_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check("abort_ready_release", 32'(ready_o), 1);
    for (int i = 0; i < 40; i++) @(negedge clk_i);
    check("abort_no_edges", rx_edges, 0);
    check("abort_no_done_queue", 32'(q.size()), 0);

    // DIV=1, GAP=2 instance with FFFF
    word1  = 16'hFFFF;
    valid1 = 1'b1;
    check("div1_ready", 32'(ready1), 1);
    @(negedge clk_i);
    valid1   = 1'b0;
    word1    = 16'h0000;
    err_clk  = 0;
    err_data = 0;
    err_done = 0;
    edges1   = 0;
    pc       = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (cclk1 !== ((k <= 32) ? 1'(k % 2 == 0) : 1'b0)) err_clk++;
      if (cdata1 !== 1'(k <= 32)) err_data++;
      if (done1 !== 1'(k == 34)) err_done++;
      if (cclk1 && !pc) edges1++;
      pc = cclk1;
      @(negedge clk_i);
    end
    check("div1_clk_pattern", err_clk, 0);
    check("div1_data_pattern", err_data, 0);
    check("div1_done_timing", err_done, 0);
    check("div1_edges", edges1, 16);
    check("div1_ready_after", 32'(ready1), 1);
    check("div1_done_after", 32'(done1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_tx.md
CTRL_TX -- requirements
Module: ctrl_tx

Interface
REQ-001 Parameter DIV, default 4: clk_i cycles per ctrl_clk_o half-period; legal range 1..255.
REQ-002 Parameter GAP, default 16: clk_i cycles of inter-frame gap; legal range 2..1023.
REQ-003 clk_i  input  1  sole clock; all logic is posedge clk_i.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 word_i  input  16  control word to send; bit 0 = reset, bit 1 = enable, bits 3:2 = speed, bit 4 = test.
REQ-006 valid_i  input  1  word_i is valid.
REQ-007 ready_o  output  1  transmitter accepts a word this cycle.
REQ-008 busy_o  output  1  a frame (bits or gap) is in progress.
REQ-009 done_o  output  1  one-cycle pulse at the end of a frame's gap.
REQ-010 ctrl_clk_o  output  1  serial control clock.
REQ-011 ctrl_data_o  output  1  serial control data.

Function
REQ-012 The transmitter SHALL drive the serial link consumed by the sniffer's ctrl receiver: 16 bits, MSB (bit 15) first, data stable while ctrl_clk_o is high, sampled on the ctrl_clk_o rising edge.
REQ-013 The transmitter SHALL use FSM states IDLE, LOW, HIGH and GAP.
REQ-014 IDLE SHALL assert ready_o, hold ctrl_clk_o=0 and ctrl_data_o=0, and keep busy_o=0.
REQ-015 Accept SHALL be valid_i && ready_o at a clk_i edge; at that edge word_i is latched into a 16-bit shift register, the bit counter is set to 15, and the FSM goes to LOW.
REQ-016 A word presented while ready_o=0 SHALL NOT be latched; valid_i may stay high, and acceptance occurs on the first cycle ready_o returns high.
REQ-017 LOW SHALL last exactly DIV cycles with ctrl_clk_o=0 and ctrl_data_o=current MSB of the shift register; the FSM then goes to HIGH.
REQ-018 HIGH SHALL last exactly DIV cycles with ctrl_clk_o=1 and ctrl_data_o unchanged.
REQ-019 At the end of HIGH, if the bit counter is not 0, the shift register SHALL shift left one position, the counter SHALL decrement, and the FSM SHALL go to LOW.
REQ-020 At the end of HIGH with the bit counter at 0, the FSM SHALL go to GAP.
REQ-021 GAP SHALL last exactly GAP cycles with ctrl_clk_o=0 and ctrl_data_o=0; on its last cycle done_o=1, then the FSM goes to IDLE.
REQ-022 ctrl_clk_o and ctrl_data_o SHALL be registered outputs with no combinational path from any input.
REQ-023 busy_o SHALL equal (state != IDLE); ready_o SHALL equal (state == IDLE) && !reset_i.
REQ-024 The first LOW cycle SHALL be the cycle immediately after the accepting edge, giving one cycle of latency.
REQ-025 Frame length SHALL be 32*DIV + GAP cycles from first LOW cycle to last GAP cycle; the next accept is possible on the following cycle.
REQ-026 Back-to-back frames with valid_i held high SHALL produce a ready_o gap of exactly 32*DIV + GAP cycles.
REQ-027 The half-period counter SHALL be 8 bits and the gap counter 10 bits; counters SHALL reload on every state change and never wrap within a state.
REQ-028 When DIV=1, ctrl_clk_o SHALL toggle every clk_i cycle without skipped or doubled phases.

Reset
REQ-029 Asserting reset_i SHALL immediately force: state IDLE, ctrl_clk_o=0, ctrl_data_o=0, done_o=0, busy_o=0, ready_o=0, and the shift register and all counters to 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame without emitting a further ctrl_clk_o rising edge; the partial word is discarded.
REQ-031 After reset_i deasserts, ready_o SHALL be 1 in the first cycle.

Structure
REQ-032 Package ctrl_pkg SHALL hold CTRL_W=16, the bit-position constants for reset/enable/speed/test, and the FSM state encoding.
REQ-033 The receiver and the top level SHALL use the same ctrl_pkg constants.
REQ-034 The block SHALL be a single module with no sub-modules; the half-period/gap counter is inline.

Verification
REQ-035 DIV=4, GAP=16, word 16'h001B -> 16 rising edges of ctrl_clk_o, data bits 0000_0000_0001_1011 MSB first, done_o 144 cycles after accept edge.
REQ-036 Loopback into the ctrl receiver, word 16'h0013 -> receiver ctrl_o == 16'h0013 after done_o; reset=1, enable=1, speed=0, test=1.
REQ-037 valid_i held high with words A5A5 then 5A5A -> two frames, ready_o low exactly 144 cycles between the two accepts, second frame bits = 5A5A.
REQ-038 reset_i pulsed after the 7th rising edge of ctrl_clk_o -> ctrl_clk_o and ctrl_data_o are 0 in the same cycle, no further edges, ready_o=1 one cycle after release.
REQ-039 DIV=1, GAP=2, word 16'hFFFF -> ctrl_clk_o period 2 cycles, ctrl_data_o=1 for 32 cycles, done_o 34 cycles after accept.
REQ-040 Word changed while busy_o=1 -> transmitted bits unchanged, ready_o stays 0 until the gap ends.
